led_bus_ctrl: RTL and testbench
===============================

// Module: led_bus_ctrl
// PURPOSE
//  Memory-mapped LED controller between the CPU load/store path and the board LED driver stage.
//  Latches CPU writes into DATA/MODE/PERIOD registers and drives ledwrite/ledwdata every cycle.
//  The driver clears its LEDs whenever ledwrite is low, so this block holds ledwrite high while enabled.
//  Static, blink and rotate display modes, with a programmable tick prescaler.
// PARAMETERS
//  CNT_W    24   width of PERIOD register and tick counter
//  LED_W    8    number of LEDs / width of ledwdata
// PORTS
//  led_clk     in   1      system clock, all state on rising edge
//  ledrst      in   1      asynchronous reset, active high
//  ledctrl     in   1      chip select from address decoder (LED IO window)
//  mem_write   in   1      bus write strobe, qualified by ledctrl
//  mem_read    in   1      bus read strobe, qualified by ledctrl
//  addr        in   4      byte offset in window: 0x0 DATA, 0x4 MODE, 0x8 PERIOD
//  wdata       in   32     bus write data
//  rdata       out  32     bus read data, registered
//  ledwrite    out  1      write enable to LED driver
//  ledwdata    out  LED_W  pattern to LED driver
// BEHAVIOUR
//  - Reset (async, ledrst=1): DATA=0, MODE=0, PERIOD=0, counter=0, shadow=0, blink_phase=1;
//    outputs ledwrite=0, ledwdata=0, rdata=0.
//  - Register write: ledctrl&mem_write at edge N updates the register at N; effect on outputs at N+1.
//    DATA=wdata[LED_W-1:0]; MODE=wdata[2:0] (bits[1:0] mode, bit2 EN); PERIOD=wdata[CNT_W-1:0].
//    Unmapped offsets: write ignored, read returns 0.
//  - Read: ledctrl&mem_read at edge N -> rdata valid after N (1-cycle latency), zero-extended.
//    DATA reads the programmed value, not the rotated shadow. rdata holds its value when not reading.
//  - mem_write&mem_read in the same cycle: write applies; rdata returns the pre-write value.
//  - Tick: counter increments each cycle. When counter==PERIOD: tick=1 and counter->0.
//    PERIOD=0 gives a tick every cycle.
//  - A write to PERIOD or MODE clears counter and suppresses tick in that cycle.
//  - Modes (MODE[1:0]):
//    - 00 static: ledwdata=DATA.
//    - 01 blink: on tick, blink_phase toggles; ledwdata = phase ? DATA : 0.
//    - 10 rotate: on tick, shadow rotates left by 1 (MSB->LSB); ledwdata=shadow.
//    - 11 reserved: behaves as static.
//  - Entering blink sets blink_phase=1. Entering rotate loads shadow=DATA.
//    A DATA write while in rotate reloads shadow=DATA; a same-cycle tick is ignored (write wins).
//  - ledwrite = registered MODE[2]. When EN=0, ledwdata is forced to 0; counter and shadow keep running.
//  - All outputs are registers; no combinational path from bus inputs to ledwrite/ledwdata/rdata.
// STRUCTURE
//  - Shared package/header: register offsets (LED_DATA_OFF=4'h0, LED_MODE_OFF=4'h4, LED_PERIOD_OFF=4'h8)
//    and mode codes (LED_MODE_STATIC=2'b00, LED_MODE_BLINK=2'b01, LED_MODE_ROT=2'b10);
//    the address decoder and software headers use the same constants.
//  - Sub-module led_tick_gen (CNT_W): counter, PERIOD compare, clear input, tick output.
//  - Top: register file, bus read mux, mode/pattern datapath, output registers.
// TESTING
//  1. Reset mid-run: MODE=3'b110, PERIOD=2, then pulse ledrst asynchronously between edges
//     -> ledwrite=0, ledwdata=0, rdata=0 immediately; all registers read 0 afterwards.
//  2. Static: write DATA=0xA5, then MODE=3'b100 -> ledwrite=1, ledwdata=8'hA5 from the next edge;
//     MODE=3'b000 -> ledwrite=0, ledwdata=0.
//  3. Blink: DATA=0x0F, PERIOD=3, MODE=3'b101 -> ledwdata alternates 0x0F/0x00 every 4 cycles,
//     first 0x0F for 4 cycles.
//  4. Rotate: DATA=0x81, PERIOD=0, MODE=3'b110 -> ledwdata 0x81,0x03,0x06,0x0C,... per cycle;
//     DATA write 0x01 in the same cycle as a tick -> next ledwdata=0x01.
//  5. Readback: write PERIOD=0xFFFFFFFF -> read offset 0x8 returns 0x00FFFFFF one cycle later;
//     read 0xC returns 0; simultaneous read+write to DATA returns the old value.
//  6. PERIOD rewrite mid-count: PERIOD=10, wait 7 cycles, write PERIOD=2 in blink mode
//     -> next toggle exactly 3 cycles after the write.

Source files
------------

// File: rtl/led_bus_ctrl_pkg.sv
// Shared constants for the LED controller: register offsets inside the LED
// IO window and the display mode codes. The address decoder and software
// headers use the same values.
package led_bus_ctrl_pkg;

  localparam logic [3:0] LED_DATA_OFF   = 4'h0;
  localparam logic [3:0] LED_MODE_OFF   = 4'h4;
  localparam logic [3:0] LED_PERIOD_OFF = 4'h8;

  typedef enum logic [1:0] {
    LED_MODE_STATIC = 2'b00,
    LED_MODE_BLINK  = 2'b01,
    LED_MODE_ROT    = 2'b10,
    LED_MODE_RSVD   = 2'b11
  } led_mode_e;

endpackage

// File: rtl/led_bus_ctrl_if.sv
// CPU load/store bus slice seen by the LED controller.
//   ledctrl   : chip select for the LED IO window
//   mem_write : write strobe, qualified by ledctrl
//   mem_read  : read strobe, qualified by ledctrl
//   addr      : byte offset inside the window
//   wdata     : write data
//   rdata     : registered read data
interface led_bus_ctrl_if;
  logic        ledctrl;
  logic        mem_write;
  logic        mem_read;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output ledctrl, mem_write, mem_read, addr, wdata,
    input  rdata
  );

  modport slave (
    input  ledctrl, mem_write, mem_read, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/led_tick_gen.sv
// Programmable tick prescaler.
//   led_clk : clock
//   ledrst  : asynchronous reset, active high
//   clr     : clear counter and suppress this cycle's tick
//   period  : compare value; tick when counter equals it (0 = every cycle)
//   tick    : one-cycle pulse
module led_tick_gen #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             led_clk,
  input  logic             ledrst,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic             hit;

  assign hit  = (cnt == period);
  assign tick = hit & ~clr;

  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      cnt <= '0;
    end else if (clr || hit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/led_bus_ctrl.sv
// Memory-mapped LED controller between the CPU load/store path and the
// board LED driver. Holds DATA/MODE/PERIOD registers and drives the LED
// driver every cycle with static, blink or rotating patterns.
//   led_clk  : clock
//   ledrst   : asynchronous reset, active high
//   bus      : CPU bus slice (slave side)
//   ledwrite : driver write enable (registered MODE[2])
//   ledwdata : pattern to the driver, zero while disabled
import led_bus_ctrl_pkg::*;

module led_bus_ctrl #(
  parameter int unsigned CNT_W = 24,
  parameter int unsigned LED_W = 8
) (
  input  logic             led_clk,
  input  logic             ledrst,
  led_bus_ctrl_if.slave    bus,
  output logic             ledwrite,
  output logic [LED_W-1:0] ledwdata
);

  logic [LED_W-1:0] data_q;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] period_q;
  logic [LED_W-1:0] shadow_q;
  logic             phase_q;
  logic [31:0]      rdata_q;

  logic             wr_en, rd_en;
  logic             wr_data, wr_mode, wr_period;
  logic             tick;
  led_mode_e        cur_mode, new_mode;
  logic [LED_W-1:0] pattern;
  logic [31:0]      rd_val;
  logic             unused_wdata;

  assign unused_wdata = ^bus.wdata;

  assign wr_en     = bus.ledctrl & bus.mem_write;
  assign rd_en     = bus.ledctrl & bus.mem_read;
  assign wr_data   = wr_en && (bus.addr == LED_DATA_OFF);
  assign wr_mode   = wr_en && (bus.addr == LED_MODE_OFF);
  assign wr_period = wr_en && (bus.addr == LED_PERIOD_OFF);

  assign cur_mode = led_mode_e'(mode_q[1:0]);
  assign new_mode = led_mode_e'(bus.wdata[1:0]);

  led_tick_gen #(.CNT_W(CNT_W)) u_tick (
    .led_clk (led_clk),
    .ledrst  (ledrst),
    .clr     (wr_mode | wr_period),
    .period  (period_q),
    .tick    (tick)
  );

  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      data_q   <= '0;
      mode_q   <= '0;
      period_q <= '0;
    end else begin
      if (wr_data)   data_q   <= bus.wdata[LED_W-1:0];
      if (wr_mode)   mode_q   <= bus.wdata[2:0];
      if (wr_period) period_q <= bus.wdata[CNT_W-1:0];
    end
  end

  // Mode entry (re)initialises the pattern state; a DATA write in rotate
  // mode takes priority over a coincident rotate tick.
  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      phase_q  <= 1'b1;
      shadow_q <= '0;
    end else begin
      if (wr_mode && new_mode == LED_MODE_BLINK && cur_mode != LED_MODE_BLINK) begin
        phase_q <= 1'b1;
      end else if (tick && cur_mode == LED_MODE_BLINK) begin
        phase_q <= ~phase_q;
      end

      if (wr_mode && new_mode == LED_MODE_ROT && cur_mode != LED_MODE_ROT) begin
        shadow_q <= data_q;
      end else if (wr_data && cur_mode == LED_MODE_ROT) begin
        shadow_q <= bus.wdata[LED_W-1:0];
      end else if (tick && cur_mode == LED_MODE_ROT) begin
        shadow_q <= {shadow_q[LED_W-2:0], shadow_q[LED_W-1]};
      end
    end
  end

  always_comb begin
    pattern = data_q;
    case (cur_mode)
      LED_MODE_BLINK: pattern = phase_q ? data_q : '0;
      LED_MODE_ROT:   pattern = shadow_q;
      default:        pattern = data_q;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (bus.addr)
      LED_DATA_OFF:   rd_val = 32'(data_q);
      LED_MODE_OFF:   rd_val = 32'(mode_q);
      LED_PERIOD_OFF: rd_val = 32'(period_q);
      default:        rd_val = '0;
    endcase
  end

  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      ledwrite <= 1'b0;
      ledwdata <= '0;
      rdata_q  <= '0;
    end else begin
      ledwrite <= mode_q[2];
      ledwdata <= mode_q[2] ? pattern : '0;
      if (rd_en) rdata_q <= rd_val;
    end
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_led_bus_ctrl.sv
module tb_led_bus_ctrl;
  import led_bus_ctrl_pkg::*;

  logic       led_clk = 1'b0;
  logic       ledrst  = 1'b1;
  logic       ledwrite;
  logic [7:0] ledwdata;
  int         checks = 0;
  int         errors = 0;

  led_bus_ctrl_if bus();

  led_bus_ctrl #(.CNT_W(24), .LED_W(8)) dut (
    .led_clk  (led_clk),
    .ledrst   (ledrst),
    .bus      (bus),
    .ledwrite (ledwrite),
    .ledwdata (ledwdata)
  );

  always #5 led_clk = ~led_clk;

  task automatic cyc();
    @(posedge led_clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus.ledctrl = 1'b1; bus.mem_write = 1'b1; bus.addr = a; bus.wdata = d;
    cyc();
    bus.ledctrl = 1'b0; bus.mem_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus.ledctrl = 1'b1; bus.mem_read = 1'b1; bus.addr = a;
    cyc();
    d = bus.rdata;
    bus.ledctrl = 1'b0; bus.mem_read = 1'b0;
  endtask

  task automatic test_reset();
    bus.ledctrl = 1'b0; bus.mem_write = 1'b0; bus.mem_read = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    ledrst = 1'b1;
    cyc(); cyc();
    checks++;
    if (ledwrite !== 1'b0 || ledwdata !== 8'h00 || bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got w=%b d=%h r=%h exp 0/00/0", ledwrite, ledwdata, bus.rdata);
    end
    ledrst = 1'b0;
    cyc();
  endtask

  task automatic test_reset_midrun();
    logic [31:0] r;
    bus_write(LED_DATA_OFF, 32'h3C);
    bus_write(LED_MODE_OFF, 32'h6);
    bus_write(LED_PERIOD_OFF, 32'h2);
    bus_read(LED_MODE_OFF, r);
    checks++;
    if (ledwrite !== 1'b1 || r !== 32'h6) begin
      errors++;
      $display("FAIL midrun_pre got w=%b r=%h exp 1/6", ledwrite, r);
    end
    #3 ledrst = 1'b1;
    #1;
    checks++;
    if (ledwrite !== 1'b0 || ledwdata !== 8'h00 || bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL midrun_async got w=%b d=%h r=%h exp 0/00/0", ledwrite, ledwdata, bus.rdata);
    end
    #2 ledrst = 1'b0;
    cyc();
    bus_read(LED_DATA_OFF, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL midrun_data got %h exp 0", r); end
    bus_read(LED_MODE_OFF, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL midrun_mode got %h exp 0", r); end
    bus_read(LED_PERIOD_OFF, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL midrun_period got %h exp 0", r); end
  endtask

  task automatic test_static();
    bus_write(LED_DATA_OFF, 32'hA5);
    bus_write(LED_MODE_OFF, 32'h4);
    checks++;
    if (ledwrite !== 1'b0) begin errors++; $display("FAIL static_latency got w=%b exp 0", ledwrite); end
    cyc();
    checks++;
    if (ledwrite !== 1'b1 || ledwdata !== 8'hA5) begin
      errors++;
      $display("FAIL static_on got w=%b d=%h exp 1/a5", ledwrite, ledwdata);
    end
    bus_write(LED_MODE_OFF, 32'h0);
    cyc();
    checks++;
    if (ledwrite !== 1'b0 || ledwdata !== 8'h00) begin
      errors++;
      $display("FAIL static_off got w=%b d=%h exp 0/00", ledwrite, ledwdata);
    end
  endtask

  task automatic test_blink();
    logic [7:0] exp;
    bus_write(LED_DATA_OFF, 32'h0F);
    bus_write(LED_PERIOD_OFF, 32'h3);
    bus_write(LED_MODE_OFF, 32'h5);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      exp = ((((k - 1) / 4) % 2) == 0) ? 8'h0F : 8'h00;
      checks++;
      if (ledwdata !== exp || ledwrite !== 1'b1) begin
        errors++;
        $display("FAIL blink_cycle%0d got w=%b d=%h exp 1/%h", k, ledwrite, ledwdata, exp);
      end
    end
  endtask

  task automatic test_rotate();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h81; exp_seq[1] = 8'h03; exp_seq[2] = 8'h06; exp_seq[3] = 8'h0C;
    bus_write(LED_DATA_OFF, 32'h81);
    bus_write(LED_PERIOD_OFF, 32'h0);
    bus_write(LED_MODE_OFF, 32'h6);
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (ledwdata !== exp_seq[k]) begin
        errors++;
        $display("FAIL rotate_step%0d got %h exp %h", k, ledwdata, exp_seq[k]);
      end
    end
    bus_write(LED_DATA_OFF, 32'h01);
    cyc();
    checks++;
    if (ledwdata !== 8'h01) begin errors++; $display("FAIL rotate_reload got %h exp 01", ledwdata); end
    cyc();
    checks++;
    if (ledwdata !== 8'h02) begin errors++; $display("FAIL rotate_after_reload got %h exp 02", ledwdata); end
  endtask

  task automatic test_readback();
    logic [31:0] r;
    bus_write(LED_PERIOD_OFF, 32'hFFFF_FFFF);
    bus_read(LED_PERIOD_OFF, r);
    checks++;
    if (r !== 32'h00FF_FFFF) begin errors++; $display("FAIL rd_period got %h exp 00ffffff", r); end
    cyc();
    checks++;
    if (bus.rdata !== 32'h00FF_FFFF) begin errors++; $display("FAIL rd_hold got %h exp 00ffffff", bus.rdata); end
    bus_read(4'hC, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL rd_unmapped got %h exp 0", r); end
    bus_read(LED_MODE_OFF, r);
    checks++;
    if (r !== 32'h6) begin errors++; $display("FAIL rd_mode got %h exp 6", r); end
    bus.ledctrl = 1'b1; bus.mem_write = 1'b1; bus.mem_read = 1'b1;
    bus.addr = LED_DATA_OFF; bus.wdata = 32'h5A;
    cyc();
    bus.ledctrl = 1'b0; bus.mem_write = 1'b0; bus.mem_read = 1'b0;
    checks++;
    if (bus.rdata !== 32'h01) begin errors++; $display("FAIL rd_rw_old got %h exp 01", bus.rdata); end
    bus_read(LED_DATA_OFF, r);
    checks++;
    if (r !== 32'h5A) begin errors++; $display("FAIL rd_rw_new got %h exp 5a", r); end
  endtask

  task automatic test_period_rewrite();
    logic [7:0] exp;
    bus_write(LED_DATA_OFF, 32'hFF);
    bus_write(LED_PERIOD_OFF, 32'd10);
    bus_write(LED_MODE_OFF, 32'h5);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      checks++;
      if (ledwdata !== 8'hFF) begin
        errors++;
        $display("FAIL prw_wait%0d got %h exp ff", k, ledwdata);
      end
    end
    bus_write(LED_PERIOD_OFF, 32'd2);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      exp = (k == 4) ? 8'h00 : 8'hFF;
      checks++;
      if (ledwdata !== exp) begin
        errors++;
        $display("FAIL prw_after%0d got %h exp %h", k, ledwdata, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_midrun();
    test_static();
    test_blink();
    test_rotate();
    test_readback();
    test_period_rewrite();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
